// File: rtl/iter_muldiv_if.sv
// Handshake and write-back bundle between the control unit / register file and
// the iterative multiply/divide unit.
interface iter_muldiv_if #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  start;
  logic [1:0]            op;
  logic [WIDTH-1:0]      rs_data;
  logic [WIDTH-1:0]      rt_data;
  logic [REG_ADDR_W-1:0] dest;
  logic                  busy;
  logic                  done;
  logic                  regWrite;
  logic [REG_ADDR_W-1:0] writeReg;
  logic [WIDTH-1:0]      writeData;

  modport master (
    output start, op, rs_data, rt_data, dest,
    input  busy, done, regWrite, writeReg, writeData
  );

  modport slave (
    input  start, op, rs_data, rt_data, dest,
    output busy, done, regWrite, writeReg, writeData
  );
endinterface

// File: rtl/iter_muldiv_unit.sv
// Unsigned multiply/divide unit: one bit per cycle (shift-add / restoring divide),
// followed by a single write-back cycle toward the register file.
module iter_muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic         clk,
  input logic         rst,
  iter_muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, WB} state_t;

  localparam logic [1:0] OP_MULU  = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [5:0] LAST     = 6'(WIDTH - 1);

  state_t                state, state_nx;
  logic [1:0]            op_q;
  logic [WIDTH-1:0]      a_q, b_q;
  logic [REG_ADDR_W-1:0] dest_q, wreg_hold;
  logic [2*WIDTH-1:0]    prod, prod_nx;
  logic [WIDTH:0]        rem, rem_nx, shrem;
  logic [WIDTH-1:0]      quo, quo_nx, result, wdata_hold;
  logic [WIDTH:0]        sum;
  logic [5:0]            cnt;
  logic                  ge, div0;

  assign div0 = bus.op[1] && (bus.rt_data == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = div0 ? WB : CALC;
      CALC:    if (cnt == LAST) state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Multiplier sits in the low half of prod and is consumed LSB first;
  // the carry of the add lands in the top bit after the right shift.
  always_comb begin
    sum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_q} : '0);
    prod_nx = {sum, prod[WIDTH-1:1]};
    shrem   = {rem[WIDTH-1:0], quo[WIDTH-1]};
    ge      = (shrem >= {1'b0, b_q});
    rem_nx  = ge ? (shrem - {1'b0, b_q}) : shrem;
    quo_nx  = {quo[WIDTH-2:0], ge};
  end

  always_comb begin
    case (op_q)
      OP_MULU:  result = prod[WIDTH-1:0];
      OP_MULHU: result = prod[2*WIDTH-1:WIDTH];
      OP_DIVU:  result = quo;
      default:  result = rem[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      dest_q     <= '0;
      prod       <= '0;
      rem        <= '0;
      quo        <= '0;
      cnt        <= '0;
      wreg_hold  <= '0;
      wdata_hold <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          op_q   <= bus.op;
          a_q    <= bus.rs_data;
          b_q    <= bus.rt_data;
          dest_q <= bus.dest;
          cnt    <= '0;
          prod   <= {{WIDTH{1'b0}}, bus.rt_data};
          // Divide by zero skips CALC, so the final values are loaded here.
          if (div0) begin
            quo <= '1;
            rem <= {1'b0, bus.rs_data};
          end else begin
            quo <= bus.rs_data;
            rem <= '0;
          end
        end
        CALC: begin
          cnt <= cnt + 6'd1;
          if (op_q[1]) begin
            rem <= rem_nx;
            quo <= quo_nx;
          end else begin
            prod <= prod_nx;
          end
        end
        WB: begin
          wreg_hold  <= dest_q;
          wdata_hold <= result;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == WB);
  assign bus.regWrite  = (state == WB) && (dest_q != '0);
  assign bus.writeReg  = (state == WB) ? dest_q : wreg_hold;
  assign bus.writeData = (state == WB) ? result : wdata_hold;
endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Directed vector bench for iter_muldiv_unit: table of operations plus
// hand-written sequences for ignored start and mid-operation reset.
module tb_iter_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iter_muldiv_if #(.WIDTH(32), .REG_ADDR_W(5)) bus ();
  iter_muldiv_unit #(.WIDTH(32), .REG_ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  dest;
    logic [31:0] exp;
    int          cap;   // edges after start edge at which the RF captures
    logic        rw;
  } vec_t;

  int passed = 0;
  int total  = 0;
  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [4:0] dest);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.rs_data = rs; bus.rt_data = rt; bus.dest = dest;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_wb(output int k, output int bc);
    k  = 0;
    bc = bus.busy ? 1 : 0;
    while (!bus.done && k < 100) begin
      @(posedge clk); #1;
      k++;
      if (bus.busy) bc++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k, bc;
    string t;
    t = $sformatf("v%0d", idx);
    issue(v.op, v.rs, v.rt, v.dest);
    wait_wb(k, bc);
    chk({t, "_done"}, 32'(bus.done), 32'd1);
    chk({t, "_capture_edge"}, 32'(k + 1), 32'(v.cap));
    chk({t, "_busy_cycles"}, 32'(bc), 32'(v.cap));
    chk({t, "_writeReg"}, 32'(bus.writeReg), 32'(v.dest));
    chk({t, "_writeData"}, bus.writeData, v.exp);
    chk({t, "_regWrite"}, 32'(bus.regWrite), 32'(v.rw));
    @(posedge clk); #1;
    chk({t, "_idle_after"}, {29'd0, bus.busy, bus.done, bus.regWrite}, 32'd0);
    chk({t, "_hold_data"}, bus.writeData, v.exp);
  endtask

  initial begin
    int k, bc, nd;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_data = '0; bus.rt_data = '0; bus.dest = '0;

    vecs[0]  = '{2'b00, 32'd7,        32'd6,        5'd3, 32'd42,       33, 1'b1};
    vecs[1]  = '{2'b01, 32'd7,        32'd6,        5'd3, 32'd0,        33, 1'b1};
    vecs[2]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'h00000001, 33, 1'b1};
    vecs[3]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFE, 33, 1'b1};
    vecs[4]  = '{2'b10, 32'd100,      32'd7,        5'd5, 32'd14,       33, 1'b1};
    vecs[5]  = '{2'b11, 32'd100,      32'd7,        5'd5, 32'd2,        33, 1'b1};
    vecs[6]  = '{2'b10, 32'h1234,     32'd0,        5'd6, 32'hFFFFFFFF, 1,  1'b1};
    vecs[7]  = '{2'b11, 32'h1234,     32'd0,        5'd7, 32'h00001234, 1,  1'b1};
    vecs[8]  = '{2'b00, 32'd3,        32'd5,        5'd0, 32'd15,       33, 1'b0};
    vecs[9]  = '{2'b11, 32'd7,        32'd9,        5'd9, 32'd7,        33, 1'b1};
    vecs[10] = '{2'b10, 32'hFFFFFFFF, 32'd1,        5'd31, 32'hFFFFFFFF, 33, 1'b1};
    vecs[11] = '{2'b01, 32'h00010000, 32'h00030000, 5'd4, 32'h00000003, 33, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {29'd0, bus.busy, bus.done, bus.regWrite}, 32'd0);
    chk("reset_writeReg", 32'(bus.writeReg), 32'd0);
    chk("reset_writeData", bus.writeData, 32'd0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // start pulsed during CALC must be ignored entirely
    issue(2'b00, 32'd3, 32'd5, 5'd2);
    repeat (10) begin @(posedge clk); #1; end
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.rs_data = 32'd9; bus.rt_data = 32'd3; bus.dest = 5'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_wb(k, bc);
    chk("ign_done", 32'(bus.done), 32'd1);
    chk("ign_capture_edge", 32'(k + 12), 32'd33);
    chk("ign_writeReg", 32'(bus.writeReg), 32'd2);
    chk("ign_writeData", bus.writeData, 32'd15);
    nd = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.done) nd++; end
    chk("ign_single_wb", 32'(nd), 32'd0);

    // asynchronous reset in the middle of a divide
    issue(2'b10, 32'd1000, 32'd10, 5'd6);
    repeat (10) begin @(posedge clk); #1; end
    #2; rst = 1'b1; #1;
    chk("rst_ctrl", {29'd0, bus.busy, bus.done, bus.regWrite}, 32'd0);
    chk("rst_writeData", bus.writeData, 32'd0);
    chk("rst_writeReg", 32'(bus.writeReg), 32'd0);
    @(posedge clk); @(negedge clk); rst = 1'b0;
    nd = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.done || bus.busy) nd++; end
    chk("rst_no_wb", 32'(nd), 32'd0);
    run_vec('{2'b10, 32'd1000, 32'd10, 5'd1, 32'd100, 33, 1'b1}, 99);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
